// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue controller.
package div_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } div_state_t;

    // Per-instruction context captured at issue, used for post-correction.
    typedef struct packed {
        logic signed_op;
        logic rem_op;
        logic neg_q;
        logic neg_r;
    } div_ctx_t;

    // Two's-complement magnitude; INT_MIN maps to itself, which is correct as unsigned.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// AXI-stream channels between the issue controller and the unsigned divider core.
interface div_issue_ctrl_if import div_pkg::*; ();

    logic                dividend_tvalid;
    logic [XLEN-1:0]     dividend_tdata;
    logic                dividend_tready;
    logic                divisor_tvalid;
    logic [XLEN-1:0]     divisor_tdata;
    logic                divisor_tready;
    logic                dout_tvalid;
    logic [2*XLEN-1:0]   dout_tdata;

    modport master (
        output dividend_tvalid, dividend_tdata,
        input  dividend_tready,
        output divisor_tvalid, divisor_tdata,
        input  divisor_tready,
        input  dout_tvalid, dout_tdata
    );

    modport slave (
        input  dividend_tvalid, dividend_tdata,
        output dividend_tready,
        input  divisor_tvalid, divisor_tdata,
        output divisor_tready,
        output dout_tvalid, dout_tdata
    );

endinterface

// File: rtl/div_sign_fix.sv
// Applies sign post-correction to the unsigned core result and selects quotient or remainder.
module div_sign_fix import div_pkg::*; (
    input  logic [2*XLEN-1:0] dout,
    input  div_ctx_t          ctx,
    output logic [XLEN-1:0]   result_c
);

    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // Negate quotient/remainder when the signed operands call for it.
    always_comb begin
        q        = dout[2*XLEN-1:XLEN];
        r        = dout[XLEN-1:0];
        q_fix    = (ctx.signed_op && ctx.neg_q) ? (~q + 1'b1) : q;
        r_fix    = (ctx.signed_op && ctx.neg_r) ? (~r + 1'b1) : r;
        result_c = ctx.rem_op ? r_fix : q_fix;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU/REM/REMU from EX onto a shared unsigned divider core, owns the EX stall.
module div_issue_ctrl import div_pkg::*; (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    div_issue_ctrl_if.master core
);

    div_state_t      state_q, state_d;
    div_ctx_t        ctx_q, ctx_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            dvd_tvalid_q, dvd_tvalid_d;
    logic            dvs_tvalid_q, dvs_tvalid_d;
    logic [XLEN-1:0] dvd_tdata_q, dvd_tdata_d;
    logic [XLEN-1:0] dvs_tdata_q, dvs_tdata_d;
    logic            kill_q, kill_d;

    logic            req_div;
    div_ctx_t        req_ctx;
    logic            dvd_ok;
    logic            dvs_ok;
    logic [XLEN-1:0] fix_result;

    div_sign_fix u_sign_fix (
        .dout     (core.dout_tdata),
        .ctx      (ctx_q),
        .result_c (fix_result)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ctx_q        <= '0;
            result_q     <= '0;
            dvd_tvalid_q <= 1'b0;
            dvs_tvalid_q <= 1'b0;
            dvd_tdata_q  <= '0;
            dvs_tdata_q  <= '0;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctx_q        <= ctx_d;
            result_q     <= result_d;
            dvd_tvalid_q <= dvd_tvalid_d;
            dvs_tvalid_q <= dvs_tvalid_d;
            dvd_tdata_q  <= dvd_tdata_d;
            dvs_tdata_q  <= dvs_tdata_d;
            kill_q       <= kill_d;
        end
    end

    // Next-state, handshake and result selection.
    always_comb begin
        state_d      = state_q;
        ctx_d        = ctx_q;
        result_d     = result_q;
        dvd_tvalid_d = dvd_tvalid_q;
        dvs_tvalid_d = dvs_tvalid_q;
        dvd_tdata_d  = dvd_tdata_q;
        dvs_tdata_d  = dvs_tdata_q;
        kill_d       = kill_q;

        // Non-divide M-ext encodings are never ours.
        req_div           = req_valid && funct3[2];
        req_ctx.signed_op = !funct3[0];
        req_ctx.rem_op    = funct3[1];
        req_ctx.neg_q     = !funct3[0] && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
        req_ctx.neg_r     = !funct3[0] && rs1_val[XLEN-1];

        // A channel counts as accepted once its tvalid has dropped or it handshakes now.
        dvd_ok = !dvd_tvalid_q || core.dividend_tready;
        dvs_ok = !dvs_tvalid_q || core.divisor_tready;

        unique case (state_q)
            IDLE: begin
                if (req_div && !flush) begin
                    ctx_d  = req_ctx;
                    kill_d = 1'b0;
                    if (rs2_val == '0) begin
                        result_d = req_ctx.rem_op ? rs1_val : ALL_ONES;
                        state_d  = DONE;
                    end else if (req_ctx.signed_op && rs1_val == INT_MIN && rs2_val == ALL_ONES) begin
                        result_d = req_ctx.rem_op ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else begin
                        dvd_tdata_d  = abs_val(rs1_val, req_ctx.signed_op);
                        dvs_tdata_d  = abs_val(rs2_val, req_ctx.signed_op);
                        dvd_tvalid_d = 1'b1;
                        dvs_tvalid_d = 1'b1;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // tvalid is never withdrawn; a flush is remembered and drained later.
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (dvd_tvalid_q && core.dividend_tready) begin
                    dvd_tvalid_d = 1'b0;
                end
                if (dvs_tvalid_q && core.divisor_tready) begin
                    dvs_tvalid_d = 1'b0;
                end
                if (dvd_ok && dvs_ok) begin
                    state_d = (kill_q || flush) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    // Output arriving in the flush cycle is already the one to discard.
                    state_d = core.dout_tvalid ? IDLE : DRAIN;
                end else if (core.dout_tvalid) begin
                    result_d = fix_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (core.dout_tvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall = reset_n && !flush &&
                   ((state_q == IDLE && req_div) || state_q == ISSUE ||
                    state_q == WAIT || (state_q == DRAIN && req_div));

    assign result_valid         = (state_q == DONE) && !flush;
    assign result               = result_q;
    assign core.dividend_tvalid = dvd_tvalid_q;
    assign core.dividend_tdata  = dvd_tdata_q;
    assign core.divisor_tvalid  = dvs_tvalid_q;
    assign core.divisor_tdata   = dvs_tdata_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural unsigned divider core.
module tb_div_issue_ctrl;
    import div_pkg::*;

    localparam int CORE_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        rdy_dvd;
    logic        rdy_dvs;

    div_issue_ctrl_if core ();

    div_issue_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .funct3       (funct3),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .flush        (flush),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid),
        .core         (core)
    );

    always #5 clk = ~clk;

    assign core.dividend_tready = rdy_dvd;
    assign core.divisor_tready  = rdy_dvs;

    // Behavioural divider core: captures operands, answers CORE_LAT cycles later.
    logic [31:0] cm_a, cm_b;
    logic        cm_ha, cm_hb;
    int          cm_cnt;
    int          n_issue = 0;
    int          n_emit  = 0;
    int          ovr_idx = -1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cm_ha            <= 1'b0;
            cm_hb            <= 1'b0;
            cm_cnt           <= CORE_LAT;
            core.dout_tvalid <= 1'b0;
            core.dout_tdata  <= '0;
        end else begin
            core.dout_tvalid <= 1'b0;
            if (cm_ha && cm_hb) begin
                if (cm_cnt == 0) begin
                    core.dout_tvalid <= 1'b1;
                    core.dout_tdata  <= (n_emit == ovr_idx) ? {32'd9, 32'd9} : {cm_a / cm_b, cm_a % cm_b};
                    cm_ha            <= 1'b0;
                    cm_hb            <= 1'b0;
                    cm_cnt           <= CORE_LAT;
                    n_emit           <= n_emit + 1;
                end else begin
                    cm_cnt <= cm_cnt - 1;
                end
            end
            if (core.dividend_tvalid && core.dividend_tready) begin
                cm_a    <= core.dividend_tdata;
                cm_ha   <= 1'b1;
                n_issue <= n_issue + 1;
            end
            if (core.divisor_tvalid && core.divisor_tready) begin
                cm_b  <= core.divisor_tdata;
                cm_hb <= 1'b1;
            end
        end
    end

    // Free-running activity counters sampled away from the active edge.
    int n_stall = 0, n_rv = 0, n_dvd_tv = 0, n_dvs_tv = 0;
    always @(negedge clk) begin
        if (stall)                n_stall  <= n_stall + 1;
        if (result_valid)         n_rv     <= n_rv + 1;
        if (core.dividend_tvalid) n_dvd_tv <= n_dvd_tv + 1;
        if (core.divisor_tvalid)  n_dvs_tv <= n_dvs_tv + 1;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the completion pulse; n counts sampled cycles including DONE.
    task automatic wait_done(output bit got, output logic [31:0] r, output int n);
        got = 1'b0;
        r   = '0;
        n   = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (result_valid) begin
                got = 1'b1;
                r   = result;
            end
        end
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        funct3    = f3;
        rs1_val   = a;
        rs2_val   = b;
        req_valid = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [31:0] exp_dvd;
        logic [31:0] exp_dvs;
        bit          via_core;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit          got;
        logic [31:0] r;
        int          n;
        int          s_st, s_rv, s_is, s_dvd, s_dvs;

        // Hand-computed vectors: operands, expected result, expected core operands.
        vecs.push_back('{F3_DIV,  32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA, 32'd20,        32'd3,         1'b1});
        vecs.push_back('{F3_REM,  32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFE, 32'd20,        32'd3,         1'b1});
        vecs.push_back('{F3_DIVU, 32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0});
        vecs.push_back('{F3_REMU, 32'd7,         32'd0,          32'd7,         32'd0,         32'd0,         1'b0});
        vecs.push_back('{F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         32'd0,         1'b0});
        vecs.push_back('{F3_REM,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'd0,         32'd0,         1'b0});
        vecs.push_back('{F3_DIVU, 32'd100,       32'd7,          32'd14,        32'd100,       32'd7,         1'b1});
        vecs.push_back('{F3_REMU, 32'd100,       32'd7,          32'd2,         32'd100,       32'd7,         1'b1});
        vecs.push_back('{F3_DIV,  32'h0000_0014, 32'hFFFF_FFFD,  32'hFFFF_FFFA, 32'd20,        32'd3,         1'b1});
        vecs.push_back('{F3_REM,  32'h0000_0014, 32'hFFFF_FFFD,  32'd2,         32'd20,        32'd3,         1'b1});
        vecs.push_back('{F3_DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFD,  32'd6,         32'd20,        32'd3,         1'b1});
        vecs.push_back('{F3_REM,  32'hFFFF_FFEC, 32'hFFFF_FFFD,  32'hFFFF_FFFE, 32'd20,        32'd3,         1'b1});
        vecs.push_back('{F3_DIV,  32'h8000_0000, 32'd2,          32'hC000_0000, 32'h8000_0000, 32'd2,         1'b1});
        vecs.push_back('{F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{F3_REMU, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{F3_REM,  32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'd0,         32'd0,         1'b0});

        reset_n   = 1'b0;
        req_valid = 1'b0;
        funct3    = 3'b000;
        rs1_val   = '0;
        rs2_val   = '0;
        flush     = 1'b0;
        rdy_dvd   = 1'b1;
        rdy_dvs   = 1'b1;

        // Reset values.
        #12;
        check("rst_stall",  32'(stall), 32'd0);
        check("rst_rv",     32'(result_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_tvalid", {30'd0, core.dividend_tvalid, core.divisor_tvalid}, 32'd0);
        check("rst_tdata",  core.dividend_tdata | core.divisor_tdata, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single-instruction vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            drive_req(vecs[i].f3, vecs[i].a, vecs[i].b);
            s_st = n_stall;
            s_rv = n_rv;
            s_is = n_issue;
            wait_done(got, r, n);
            @(posedge clk); #1;
            req_valid = 1'b0;
            check($sformatf("v%0d_done", i),   32'(got), 32'd1);
            check($sformatf("v%0d_result", i), r, vecs[i].exp_res);
            check($sformatf("v%0d_rvcnt", i),  32'(n_rv - s_rv), 32'd1);
            check($sformatf("v%0d_stall", i),  32'(n_stall - s_st), 32'(n - 1));
            check($sformatf("v%0d_issues", i), 32'(n_issue - s_is), 32'(vecs[i].via_core));
            if (vecs[i].via_core) begin
                check($sformatf("v%0d_dvd", i), cm_a, vecs[i].exp_dvd);
                check($sformatf("v%0d_dvs", i), cm_b, vecs[i].exp_dvs);
            end
            @(posedge clk); #1;
        end

        // Dividend backpressure for 5 cycles while the divisor is accepted at once.
        rdy_dvd = 1'b0;
        drive_req(F3_DIVU, 32'd100, 32'd7);
        s_st  = n_stall;
        s_rv  = n_rv;
        s_dvd = n_dvd_tv;
        s_dvs = n_dvs_tv;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_tvalid%0d", k), 32'(core.dividend_tvalid), 32'd1);
            check($sformatf("bp_tdata%0d", k),  core.dividend_tdata, 32'd100);
            check($sformatf("bp_stall%0d", k),  32'(stall), 32'd1);
        end
        @(posedge clk); #1;
        rdy_dvd = 1'b1;
        wait_done(got, r, n);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_done",    32'(got), 32'd1);
        check("bp_result",  r, 32'd14);
        check("bp_dvd_cyc", 32'(n_dvd_tv - s_dvd), 32'd6);
        check("bp_dvs_cyc", 32'(n_dvs_tv - s_dvs), 32'd1);
        check("bp_stall",   32'(n_stall - s_st), 32'(6 + n - 1));
        check("bp_rvcnt",   32'(n_rv - s_rv), 32'd1);
        @(posedge clk); #1;

        // Flush while idle: nothing is issued and the stall is suppressed.
        s_is = n_issue;
        drive_req(F3_DIVU, 32'd50, 32'd5);
        flush = 1'b1;
        @(negedge clk);
        check("fidle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fidle_issue", 32'(n_issue - s_is), 32'd0);
        check("fidle_tvalid", 32'(core.dividend_tvalid), 32'd0);

        // Flush in WAIT: the core answer {9,9} is drained, then the next op issues once.
        ovr_idx = n_emit;
        s_is    = n_issue;
        s_rv    = n_rv;
        drive_req(F3_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        flush     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("fwait_stall", 32'(stall), 32'd0);
        check("fwait_rv",    32'(result_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        drive_req(F3_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        check("drain_stall",  32'(stall), 32'd1);
        check("drain_tvalid", 32'(core.dividend_tvalid), 32'd0);
        wait_done(got, r, n);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("fwait_done",   32'(got), 32'd1);
        check("fwait_result", r, 32'd14);
        check("fwait_rvcnt",  32'(n_rv - s_rv), 32'd1);
        check("fwait_issues", 32'(n_issue - s_is), 32'd2);
        @(posedge clk); #1;

        // Reset during WAIT clears every output in the same cycle.
        drive_req(F3_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("mrst_stall",  32'(stall), 32'd0);
        check("mrst_rv",     32'(result_valid), 32'd0);
        check("mrst_result", result, 32'd0);
        check("mrst_tvalid", {30'd0, core.dividend_tvalid, core.divisor_tvalid}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        s_rv = n_rv;
        drive_req(F3_DIV, 32'h0000_0014, 32'hFFFF_FFFD);
        wait_done(got, r, n);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mrst_done",   32'(got), 32'd1);
        check("mrst_after",  r, 32'hFFFF_FFFA);
        check("mrst_rvcnt",  32'(n_rv - s_rv), 32'd1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
